// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared opcode/funct constants, ALU encodings and control types for the ID/EX stage
package id_ex_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLL  = 3'b100;
    localparam logic [2:0] ALU_SRL  = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_PASS = 3'b111;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic illegal;
    } ctrl_flags_t;

    // Where each ALU operand comes from; CONST is the extended immediate or shamt.
    typedef enum logic [1:0] {SRC_RS, SRC_RT, SRC_CONST} op_src_t;
    typedef enum logic [1:0] {IMM_SIGN, IMM_ZERO, IMM_LUI, IMM_SHAMT} imm_kind_t;

endpackage

// File: rtl/id_ex_stage_alu_ctrl_decode.sv
// rtl/id_ex_stage_alu_ctrl_decode.sv - combinational opcode/funct to ALU control, flags and operand sources
module alu_ctrl_decode
    import id_ex_stage_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic [2:0]  control,
    output ctrl_flags_t flags,
    output op_src_t     in1_src,
    output op_src_t     in2_src,
    output imm_kind_t   imm_kind,
    output logic        dst_rd
);

    always_comb begin
        control  = ALU_PASS;
        flags    = '0;
        in1_src  = SRC_RS;
        in2_src  = SRC_RT;
        imm_kind = IMM_SIGN;
        dst_rd   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dst_rd          = 1'b1;
                flags.reg_write = 1'b1;
                case (funct)
                    FN_ADD: control = ALU_ADD;
                    FN_SUB: control = ALU_SUB;
                    FN_AND: control = ALU_AND;
                    FN_OR:  control = ALU_OR;
                    FN_SLT: control = ALU_SLT;
                    FN_SLL: begin
                        control  = ALU_SLL;
                        in1_src  = SRC_CONST;
                        imm_kind = IMM_SHAMT;
                    end
                    FN_SRL: begin
                        control  = ALU_SRL;
                        in1_src  = SRC_RT;
                        in2_src  = SRC_CONST;
                        imm_kind = IMM_SHAMT;
                    end
                    default: begin
                        flags.reg_write = 1'b0;
                        flags.illegal   = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin control = ALU_ADD; in2_src = SRC_CONST; flags.reg_write = 1'b1; end
            OP_SLTI: begin control = ALU_SLT; in2_src = SRC_CONST; flags.reg_write = 1'b1; end
            OP_ANDI: begin
                control = ALU_AND; in2_src = SRC_CONST; imm_kind = IMM_ZERO; flags.reg_write = 1'b1;
            end
            OP_ORI: begin
                control = ALU_OR; in2_src = SRC_CONST; imm_kind = IMM_ZERO; flags.reg_write = 1'b1;
            end
            OP_LUI: begin
                control = ALU_PASS; in2_src = SRC_CONST; imm_kind = IMM_LUI; flags.reg_write = 1'b1;
            end
            OP_LW: begin
                control = ALU_ADD; in2_src = SRC_CONST; flags.reg_write = 1'b1; flags.mem_read = 1'b1;
            end
            OP_SW:  begin control = ALU_ADD; in2_src = SRC_CONST; flags.mem_write = 1'b1; end
            // Branch compares rs against rt; the ALU zero flag resolves it.
            OP_BEQ: begin control = ALU_SUB; flags.branch = 1'b1; end
            default: flags.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register feeding the ALU, with handshake, stall, flush
// and optional EX/MEM, MEM/WB operand forwarding enabled by ID_EX_FORWARD_EN.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [5:0]        id_opcode,
    input  logic [5:0]        id_funct,
    input  logic [4:0]        id_shamt,
    input  logic [15:0]       id_imm,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic              flush,
    input  logic              ex_ready,
    input  logic              exmem_wr,
    input  logic              memwb_wr,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] exmem_res,
    input  logic [DATA_W-1:0] memwb_res,
    output logic              ex_valid,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [2:0]        alu_control,
    output logic [REG_AW-1:0] ex_dst,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_branch,
    output logic              ex_illegal
);

    logic [2:0]        dec_control;
    ctrl_flags_t       dec_flags;
    op_src_t           dec_in1_src;
    op_src_t           dec_in2_src;
    imm_kind_t         dec_imm_kind;
    logic              dec_dst_rd;
    logic [DATA_W-1:0] dec_const;

    ctrl_flags_t       flags_q;
    op_src_t           in1_src_q;
    op_src_t           in2_src_q;
    logic [REG_AW-1:0] rs_addr_q;
    logic [REG_AW-1:0] rt_addr_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] const_q;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;

    alu_ctrl_decode u_decode (
        .opcode   (id_opcode),
        .funct    (id_funct),
        .control  (dec_control),
        .flags    (dec_flags),
        .in1_src  (dec_in1_src),
        .in2_src  (dec_in2_src),
        .imm_kind (dec_imm_kind),
        .dst_rd   (dec_dst_rd)
    );

    always_comb begin
        case (dec_imm_kind)
            IMM_ZERO:  dec_const = {{(DATA_W-16){1'b0}}, id_imm};
            IMM_LUI:   dec_const = {id_imm, {(DATA_W-16){1'b0}}};
            IMM_SHAMT: dec_const = {{(DATA_W-5){1'b0}}, id_shamt};
            default:   dec_const = {{(DATA_W-16){id_imm[15]}}, id_imm};
        endcase
    end

    assign id_ready = !ex_valid || ex_ready;

    // Flush outranks capture; a stall (ex_valid && !ex_ready) falls through and holds everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            flags_q     <= '0;
            alu_control <= ALU_ADD;
            ex_dst      <= '0;
            in1_src_q   <= SRC_RS;
            in2_src_q   <= SRC_RS;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            const_q     <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            flags_q  <= '0;
        end else if (id_ready) begin
            ex_valid <= id_valid;
            if (id_valid) begin
                flags_q     <= dec_flags;
                alu_control <= dec_control;
                ex_dst      <= dec_dst_rd ? id_rd_addr : id_rt_addr;
                in1_src_q   <= dec_in1_src;
                in2_src_q   <= dec_in2_src;
                rs_addr_q   <= id_rs_addr;
                rt_addr_q   <= id_rt_addr;
                rs_data_q   <= id_rs_data;
                rt_data_q   <= id_rt_data;
                const_q     <= dec_const;
            end else begin
                flags_q <= '0;
            end
        end
    end

`ifdef ID_EX_FORWARD_EN
    // Applied after the register so a stalled instruction still picks up fresh results.
    always_comb begin
        rs_val = rs_data_q;
        rt_val = rt_data_q;
        if (memwb_wr && memwb_rd == rs_addr_q && rs_addr_q != '0) rs_val = memwb_res;
        if (exmem_wr && exmem_rd == rs_addr_q && rs_addr_q != '0) rs_val = exmem_res;
        if (memwb_wr && memwb_rd == rt_addr_q && rt_addr_q != '0) rt_val = memwb_res;
        if (exmem_wr && exmem_rd == rt_addr_q && rt_addr_q != '0) rt_val = exmem_res;
    end
`else
    assign rs_val = rs_data_q;
    assign rt_val = rt_data_q;
    logic unused_fwd;
    assign unused_fwd = ^{exmem_wr, exmem_rd, exmem_res, memwb_wr, memwb_rd, memwb_res,
                          rs_addr_q, rt_addr_q};
`endif

    always_comb begin
        case (in1_src_q)
            SRC_RT:    alu_in1 = rt_val;
            SRC_CONST: alu_in1 = const_q;
            default:   alu_in1 = rs_val;
        endcase
        case (in2_src_q)
            SRC_CONST: alu_in2 = const_q;
            default:   alu_in2 = rt_val;
        endcase
    end

    assign ex_reg_write = flags_q.reg_write;
    assign ex_mem_read  = flags_q.mem_read;
    assign ex_mem_write = flags_q.mem_write;
    assign ex_branch    = flags_q.branch;
    assign ex_illegal   = flags_q.illegal;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the 32-bit ALU.
- Decodes opcode/funct into the ALU's 3-bit control and registers operands and control signals.
- Applies EX/MEM and MEM/WB forwarding and presents in1/in2/control to the ALU.
- Decouples decode from execute with a valid/ready handshake, stall and flush.

Parameters:
- DATA_W, 32, datapath width; must equal the ALU width.
- REG_AW, 5, register-address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode offers an instruction.
- id_ready  out  1  stage can accept an instruction this cycle.
- id_opcode  in  6  instruction[31:26].
- id_funct  in  6  instruction[5:0].
- id_shamt  in  5  shift amount.
- id_imm  in  16  immediate.
- id_rs_addr, id_rt_addr, id_rd_addr  in  REG_AW each  register addresses.
- id_rs_data, id_rt_data  in  DATA_W each  register-file read data.
- flush  in  1  kill the held instruction; synchronous.
- ex_ready  in  1  downstream accepts the EX result.
- exmem_wr, memwb_wr  in  1 each  forwarding-source write enables.
- exmem_rd, memwb_rd  in  REG_AW each  forwarding-source destination registers.
- exmem_res, memwb_res  in  DATA_W each  forwarding-source data.
- ex_valid  out  1  registered instruction present.
- alu_in1, alu_in2  out  DATA_W each  ALU operands.
- alu_control  out  3  ALU op.
- ex_dst  out  REG_AW  write-back register.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal  out  1 each  control flags.

Behaviour:
- Reset: all registered state and outputs are 0, including ex_valid, alu_control=000, ex_dst and all flags.
- id_ready = !ex_valid || ex_ready (combinational).
- Capture on id_valid && id_ready. Latency: one cycle from capture to ex_valid=1.
- If ex_ready=1 with no new capture, ex_valid clears next cycle.
- When ex_valid && !ex_ready (stall), all registers hold.
- flush=1: ex_valid=0 next cycle and the flags clear. Flush beats a simultaneous capture; the offered instruction is dropped.
- Reset asserted mid-operation clears everything immediately, asynchronously.
- ALU control encodings: 000 add, 001 sub, 010 and, 011 or, 100 sll (in2<<in1), 101 srl (in1>>in2), 110 slt, 111 pass in2.
- R-type, opcode 0x00:
  - funct 0x20 add; 0x22 sub; 0x24 and; 0x25 or; 0x2A slt.
  - sll (funct 0x00): in1={27'b0,shamt}, in2=rt.
  - srl (funct 0x02): in1=rt, in2={27'b0,shamt}.
  - dst=rd, reg_write=1.
- I-type, dst=rt:
  - addi 0x08 add, sign-extended imm.
  - andi 0x0C and, zero-extended imm.
  - ori 0x0D or, zero-extended imm.
  - slti 0x0A slt, sign-extended imm.
  - lui 0x0F pass, in2={imm,16'b0}.
  - lw 0x23 add, mem_read=1.
  - sw 0x2B add, mem_write=1, reg_write=0.
  - beq 0x04 sub on rs,rt, branch=1, reg_write=0. The ALU zero flag resolves the branch.
- Any other opcode/funct: control=111, reg_write=mem_read=mem_write=branch=0, ex_illegal=1.
- Forwarding is combinational on the registered rs/rt data and addresses, so it stays correct across stalls.
  - Priority: EX/MEM, then MEM/WB, then register data.
  - A source matches only if its write enable is 1, its rd equals the address, and the address is nonzero.
  - Register 0 is never forwarded.
- Outputs are don't-care when ex_valid=0, except the flags, which are 0.

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- Defined: forwarding as above.
- Undefined: alu_in1/alu_in2 come only from the registered rs/rt data. Forwarding ports remain but are ignored; the hazard unit must stall instead.

Decomposition:
- Shared package holds:
  - opcode and funct constants;
  - ALU control encodings ALU_ADD..ALU_PASS (000..111);
  - a control-flag struct typedef.
- One sub-module, alu_ctrl_decode: combinational opcode/funct to control plus flags. The ALU and a later control unit reuse it.

Test Plan:
- Reset, then add r3=r1+r2 with rs=5, rt=7 -> next cycle ex_valid=1, control=000, in1=5, in2=7, ex_dst=3, reg_write=1.
- lui, imm=0x1234 -> control=111, in2=0x12340000. srl by shamt=4 with rt=0x80 -> control=101, in1=0x80, in2=4.
- Forwarding, rs=2:
  - exmem_wr=1, exmem_rd=2, exmem_res=0xAA and memwb_rd=2, memwb_res=0xBB -> in1=0xAA.
  - With exmem_wr=0 -> 0xBB.
  - With rs=0 -> 0.
- ex_ready=0 for 3 cycles while forwarded exmem_res changes 1->2 -> id_ready=0, outputs and ex_dst hold, in1 tracks to 2; the next instruction is captured the cycle after ex_ready=1.
- flush with id_valid=1 in the same cycle -> ex_valid=0 next cycle, the offered instruction does not appear; opcode 0x3F -> ex_illegal=1, reg_write=0.
